// File: rtl/fgen_burst_ctrl.sv
// Burst sequencer for funct_generator: latches a request, configures the
// generator, streams samples under FIFO backpressure and reports completion.
module fgen_burst_ctrl #(
    parameter int INT_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic signed [INT_BITS-1:0] amp_cfg_i,
    input  logic [1:0]                 sel_cfg_i,
    input  logic [CNT_W-1:0]           nsamp_i,
    input  logic                       fifo_full_i,
    output logic signed [INT_BITS-1:0] amp_o,
    output logic [1:0]                 sel_o,
    output logic                       enh_conf_o,
    output logic                       clrh_addr_o,
    output logic                       en_low_o,
    output logic                       gen_step_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic [CNT_W-1:0]           samp_cnt_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONFIG = 2'd1,
        S_GEN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                     r_state;
    logic signed [INT_BITS-1:0] r_amp;
    logic [1:0]                 r_sel;
    logic [CNT_W-1:0]           r_target;
    logic [CNT_W-1:0]           r_samp_cnt;
    logic [CNT_W-1:0]           r_stall_cnt;
    logic                       r_enh_conf;
    logic                       r_clrh_addr;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_aborted;

    logic w_in_gen;
    logic w_step;
    logic w_last;

    // Step decode: abort wins over a step in the same cycle; target 0 never ends
    assign w_in_gen = (r_state == S_GEN);
    assign w_step   = w_in_gen & ~fifo_full_i & ~abort_i;
    assign w_last   = w_step & (r_target != '0)
                    & (r_samp_cnt == (r_target - ONE));

    assign gen_step_o  = w_step;
    assign en_low_o    = ~w_in_gen;
    assign amp_o       = r_amp;
    assign sel_o       = r_sel;
    assign enh_conf_o  = r_enh_conf;
    assign clrh_addr_o = r_clrh_addr;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign aborted_o   = r_aborted;
    assign samp_cnt_o  = r_samp_cnt;
    assign stall_cnt_o = r_stall_cnt;

    // Burst FSM with registered strobes, counters and latched configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_amp       <= '0;
            r_sel       <= '0;
            r_target    <= '0;
            r_samp_cnt  <= '0;
            r_stall_cnt <= '0;
            r_enh_conf  <= 1'b0;
            r_clrh_addr <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_enh_conf  <= 1'b0;
            r_clrh_addr <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state     <= S_CONFIG;
                        r_amp       <= amp_cfg_i;
                        r_sel       <= sel_cfg_i;
                        r_target    <= nsamp_i;
                        r_samp_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_aborted   <= 1'b0;
                        r_enh_conf  <= 1'b1;
                        r_clrh_addr <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_CONFIG: begin
                    if (abort_i) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (fifo_full_i && (r_stall_cnt != '1)) begin
                        r_stall_cnt <= r_stall_cnt + ONE;
                    end
                    if (abort_i) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                    end else if (w_step) begin
                        r_samp_cnt <= r_samp_cnt + ONE;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fgen_burst_ctrl.sv
// Directed bench for fgen_burst_ctrl: cycle table plus hand-written
// sequences for abort, ignored start and mid-burst reset.
module tb_fgen_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  amp_cfg_i;
    logic [1:0]  sel_cfg_i;
    logic [15:0] nsamp_i;
    logic        fifo_full_i;
    logic [7:0]  amp_o;
    logic [1:0]  sel_o;
    logic        enh_conf_o;
    logic        clrh_addr_o;
    logic        en_low_o;
    logic        gen_step_o;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;
    logic [15:0] samp_cnt_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    fgen_burst_ctrl #(.INT_BITS(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .amp_cfg_i   (amp_cfg_i),
        .sel_cfg_i   (sel_cfg_i),
        .nsamp_i     (nsamp_i),
        .fifo_full_i (fifo_full_i),
        .amp_o       (amp_o),
        .sel_o       (sel_o),
        .enh_conf_o  (enh_conf_o),
        .clrh_addr_o (clrh_addr_o),
        .en_low_o    (en_low_o),
        .gen_step_o  (gen_step_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .aborted_o   (aborted_o),
        .samp_cnt_o  (samp_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ab;
        logic        fu;
        logic [7:0]  amp;
        logic [1:0]  sel;
        logic [15:0] n;
        logic        e_step;
        logic        e_enl;
        logic        e_conf;
        logic        e_busy;
        logic        e_done;
        logic        e_abt;
        logic [15:0] e_samp;
        logic [15:0] e_stall;
        logic [7:0]  e_amp;
        logic [1:0]  e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(
        input logic st, input logic ab, input logic fu,
        input logic [7:0] a, input logic [1:0] s, input logic [15:0] n,
        input logic es, input logic el, input logic ec,
        input logic eb, input logic ed, input logic ea,
        input logic [15:0] sc, input logic [15:0] stc,
        input logic [7:0] xa, input logic [1:0] xs);
        vec_t v;
        v.st = st; v.ab = ab; v.fu = fu;
        v.amp = a; v.sel = s; v.n = n;
        v.e_step = es; v.e_enl = el; v.e_conf = ec;
        v.e_busy = eb; v.e_done = ed; v.e_abt = ea;
        v.e_samp = sc; v.e_stall = stc;
        v.e_amp = xa; v.e_sel = xs;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic fu,
                         input logic [7:0] a, input logic [1:0] s,
                         input logic [15:0] n);
        @(negedge clk);
        start_i     = st;
        abort_i     = ab;
        fifo_full_i = fu;
        amp_cfg_i   = a;
        sel_cfg_i   = s;
        nsamp_i     = n;
        #1;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0);
    endtask

    initial begin
        int steps;
        int busy_n;
        logic seen;

        rst = 1'b1;
        start_i = 0; abort_i = 0; fifo_full_i = 0;
        amp_cfg_i = 0; sel_cfg_i = 0; nsamp_i = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // st ab fu amp sel n | step enl conf busy done abt samp stall amp sel
        addv(1,0,0,8'd100,2'd1,16'd4, 0,1,0,0,0,0, 16'd0,16'd0,8'd0,2'd0);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,1,1,0,0, 16'd0,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd0,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd1,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd2,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd3,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,1,1,0, 16'd4,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,0,0,0, 16'd4,16'd0,8'd100,2'd1);
        addv(1,0,0,8'hEC,2'd2,16'd3,  0,1,0,0,0,0, 16'd4,16'd0,8'd100,2'd1);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,1,1,0,0, 16'd0,16'd0,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd0,16'd0,8'hEC,2'd2);
        addv(0,0,1,8'd0,2'd0,16'd0,   0,0,0,1,0,0, 16'd1,16'd0,8'hEC,2'd2);
        addv(0,0,1,8'd0,2'd0,16'd0,   0,0,0,1,0,0, 16'd1,16'd1,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd1,16'd2,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd2,16'd2,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,1,1,0, 16'd3,16'd2,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,0,0,0, 16'd3,16'd2,8'hEC,2'd2);
        addv(1,0,0,8'h7F,2'd3,16'd1,  0,1,0,0,0,0, 16'd3,16'd2,8'hEC,2'd2);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,1,1,0,0, 16'd0,16'd0,8'h7F,2'd3);
        addv(0,0,1,8'd0,2'd0,16'd0,   0,0,0,1,0,0, 16'd0,16'd0,8'h7F,2'd3);
        addv(0,0,0,8'd0,2'd0,16'd0,   1,0,0,1,0,0, 16'd0,16'd1,8'h7F,2'd3);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,1,1,0, 16'd1,16'd1,8'h7F,2'd3);
        addv(0,1,0,8'd0,2'd0,16'd0,   0,1,0,0,0,0, 16'd1,16'd1,8'h7F,2'd3);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,0,0,0, 16'd1,16'd1,8'h7F,2'd3);
        addv(1,0,0,8'h0A,2'd0,16'd5,  0,1,0,0,0,0, 16'd1,16'd1,8'h7F,2'd3);
        addv(0,1,0,8'd0,2'd0,16'd0,   0,1,1,1,0,0, 16'd0,16'd0,8'h0A,2'd0);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,1,1,1, 16'd0,16'd0,8'h0A,2'd0);
        addv(0,0,0,8'd0,2'd0,16'd0,   0,1,0,0,0,1, 16'd0,16'd0,8'h0A,2'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].fu,
                  tbl[i].amp, tbl[i].sel, tbl[i].n);
            chk($sformatf("row%0d step", i), 32'(gen_step_o), 32'(tbl[i].e_step));
            chk($sformatf("row%0d en_low", i), 32'(en_low_o), 32'(tbl[i].e_enl));
            chk($sformatf("row%0d conf", i), 32'(enh_conf_o), 32'(tbl[i].e_conf));
            chk($sformatf("row%0d clr", i), 32'(clrh_addr_o), 32'(tbl[i].e_conf));
            chk($sformatf("row%0d busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i), 32'(done_o), 32'(tbl[i].e_done));
            chk($sformatf("row%0d aborted", i), 32'(aborted_o), 32'(tbl[i].e_abt));
            chk($sformatf("row%0d samp", i), 32'(samp_cnt_o), 32'(tbl[i].e_samp));
            chk($sformatf("row%0d stall", i), 32'(stall_cnt_o), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d amp", i), 32'(amp_o), 32'(tbl[i].e_amp));
            chk($sformatf("row%0d sel", i), 32'(sel_o), 32'(tbl[i].e_sel));
        end

        // Continuous burst terminated by abort after 10 steps
        drive(1'b1, 1'b0, 1'b0, 8'd50, 2'd0, 16'd0);
        idle_in();
        chk("abt config", 32'(enh_conf_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            idle_in();
            chk($sformatf("abt step%0d", i), 32'(gen_step_o), 32'd1);
            chk($sformatf("abt cnt%0d", i), 32'(samp_cnt_o), 32'(i));
        end
        drive(1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 16'd0);
        chk("abt cycle step", 32'(gen_step_o), 32'd0);
        idle_in();
        chk("abt done", 32'(done_o), 32'd1);
        chk("abt flag", 32'(aborted_o), 32'd1);
        chk("abt samp", 32'(samp_cnt_o), 32'd10);
        idle_in();
        chk("abt busy after", 32'(busy_o), 32'd0);
        chk("abt flag held", 32'(aborted_o), 32'd1);
        chk("abt samp held", 32'(samp_cnt_o), 32'd10);

        // Start pulsed mid-GEN and during DONE must be ignored
        drive(1'b1, 1'b0, 1'b0, 8'd30, 2'd2, 16'd5);
        idle_in();
        steps = 0;
        idle_in();
        if (gen_step_o) steps++;
        drive(1'b1, 1'b0, 1'b0, 8'hFB, 2'd3, 16'd1);
        if (gen_step_o) steps++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_in();
            if (gen_step_o) steps++;
            if (done_o) begin
                seen = 1'b1;
                start_i = 1'b1;
                amp_cfg_i = 8'hFB;
                nsamp_i = 16'd1;
                break;
            end
        end
        chk("ign done seen", 32'(seen), 32'd1);
        chk("ign steps", 32'(steps), 32'd5);
        chk("ign samp", 32'(samp_cnt_o), 32'd5);
        chk("ign amp", 32'(amp_o), 32'd30);
        chk("ign sel", 32'(sel_o), 32'd2);
        idle_in();
        chk("ign start in done", 32'(busy_o), 32'd0);
        chk("ign amp held", 32'(amp_o), 32'd30);

        // Reset in the middle of an 8-sample burst
        drive(1'b1, 1'b0, 1'b0, 8'd60, 2'd1, 16'd8);
        idle_in();
        idle_in();
        idle_in();
        drive(1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 16'd0);
        chk("rst pre samp", 32'(samp_cnt_o), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        fifo_full_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst amp", 32'(amp_o), 32'd0);
        chk("rst sel", 32'(sel_o), 32'd0);
        chk("rst samp", 32'(samp_cnt_o), 32'd0);
        chk("rst stall", 32'(stall_cnt_o), 32'd0);
        chk("rst conf", 32'(enh_conf_o), 32'd0);
        chk("rst clr", 32'(clrh_addr_o), 32'd0);
        chk("rst en_low", 32'(en_low_o), 32'd1);
        chk("rst step", 32'(gen_step_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst aborted", 32'(aborted_o), 32'd0);
        idle_in();
        chk("rst no done", 32'(done_o), 32'd0);
        chk("rst idle", 32'(busy_o), 32'd0);

        drive(1'b1, 1'b0, 1'b0, 8'd60, 2'd1, 16'd8);
        steps = 0;
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            idle_in();
            if (gen_step_o) steps++;
            if (busy_o) busy_n++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("clean done seen", 32'(seen), 32'd1);
        chk("clean steps", 32'(steps), 32'd8);
        chk("clean busy", 32'(busy_n), 32'd10);
        chk("clean samp", 32'(samp_cnt_o), 32'd8);
        chk("clean stall", 32'(stall_cnt_o), 32'd0);
        chk("clean amp", 32'(amp_o), 32'd60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
